// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder
// Memory-side responder for the RV32I fetch stage. PC requests are accepted on a
// valid/ready channel and turned into word reads of a fixed-latency instruction
// memory. A tag per request travels down a shift pipe that matches the memory
// latency, so every returning word meets its own PC and fault flag. Responses are
// returned in request order through a small FIFO. A flush kills every in-flight
// tag and empties the FIFO so that a branch redirect sees no stale instructions.
//
// Flow control is credit based. A credit is held from acceptance until the
// consumer pops the response. The FIFO therefore can never overflow. A pop does
// not return its credit until the next cycle, which keeps req_ready free of any
// combinational path from rsp_ready.

module instr_fetch_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int MEM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clock,
   input  logic                  sync_reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_pc,
   input  logic                  flush,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_rd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_instr,
   output logic [31:0]           rsp_pc,
   output logic                  rsp_fault
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

   // Tag pipe: one slot per cycle of memory latency
   logic        r_pipeLive  [0:MEM_LATENCY-1];
   logic [31:0] r_pipePc    [0:MEM_LATENCY-1];
   logic        r_pipeFault [0:MEM_LATENCY-1];

   // Response FIFO storage and bookkeeping
   logic [31:0]      r_fifoInstr [0:FIFO_DEPTH-1];
   logic [31:0]      r_fifoPc    [0:FIFO_DEPTH-1];
   logic             r_fifoFault [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   // Outstanding requests, counted from acceptance until the response is popped
   logic [CNT_W-1:0] r_credits;

   logic        w_fault;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic [31:0] w_pushInstr;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_ONE;
   endfunction

   // Request side: fault classification, credit-gated ready, and the memory strobe
   always_comb begin
      w_fault   = (req_pc[1:0] != 2'b00) || (req_pc[31:ADDR_WIDTH+2] != '0);
      req_ready = !sync_reset && !flush && (r_credits < DEPTH_C);
      w_accept  = req_valid && req_ready;
      mem_rd_en = w_accept && !w_fault;
      mem_addr  = req_pc[ADDR_WIDTH+1:2];
   end

   // Response side: a live tag leaving the pipe pushes, and faults swap the data for a NOP
   always_comb begin
      w_push      = r_pipeLive[MEM_LATENCY-1] && !flush;
      w_pushInstr = r_pipeFault[MEM_LATENCY-1] ? NOP_INSTR : mem_rd_data;
      w_pop       = (r_count != '0) && rsp_ready;
      rsp_valid   = !sync_reset && (r_count != '0);
      rsp_instr   = sync_reset ? '0   : r_fifoInstr[r_rdPtr];
      rsp_pc      = sync_reset ? '0   : r_fifoPc[r_rdPtr];
      rsp_fault   = sync_reset ? 1'b0 : r_fifoFault[r_rdPtr];
   end

   // Tag pipe shifts every cycle; flush kills every tag already travelling down it
   always_ff @(posedge clock) begin
      if (sync_reset) begin
         for (int i = 0; i < MEM_LATENCY; i++) begin
            r_pipeLive[i]  <= 1'b0;
            r_pipePc[i]    <= '0;
            r_pipeFault[i] <= 1'b0;
         end
      end else begin
         r_pipeLive[0]  <= w_accept;
         r_pipePc[0]    <= req_pc;
         r_pipeFault[0] <= w_fault;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            r_pipeLive[i]  <= r_pipeLive[i-1] && !flush;
            r_pipePc[i]    <= r_pipePc[i-1];
            r_pipeFault[i] <= r_pipeFault[i-1];
         end
      end
   end

   // Response FIFO; flush empties it outright, and a pop in the same cycle is simply absorbed
   always_ff @(posedge clock) begin
      if (sync_reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifoInstr[i] <= '0;
            r_fifoPc[i]    <= '0;
            r_fifoFault[i] <= 1'b0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifoInstr[r_wrPtr] <= w_pushInstr;
            r_fifoPc[r_wrPtr]    <= r_pipePc[MEM_LATENCY-1];
            r_fifoFault[r_wrPtr] <= r_pipeFault[MEM_LATENCY-1];
            r_wrPtr              <= nextPtr(r_wrPtr);
         end
         if (w_pop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + ONE_C;
            2'b01:   r_count <= r_count - ONE_C;
            default: r_count <= r_count;
         endcase
      end
   end

   // Credit counter; a pop frees its credit only for the following cycle
   always_ff @(posedge clock) begin
      if (sync_reset || flush) begin
         r_credits <= '0;
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_credits <= r_credits + ONE_C;
            2'b01:   r_credits <= r_credits - ONE_C;
            default: r_credits <= r_credits;
         endcase
      end
   end

endmodule
